btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 134 +++++++++++++
 tb/tb_btn_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronise, debounce and pulse-encode one push-button
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 200,
    parameter int CNT_W           = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press,
    output logic rel_pulse,
    output logic level,
    output logic long_press
);

    // Pin value when the button is not pressed; also the synchroniser reset value.
    localparam logic PIN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        DOWN,
        REL_CHK
    } state_t;

    logic             s1;
    logic             s2;
    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;

    // Two-flop synchroniser; only s2 is consumed by the rest of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= PIN_IDLE;
            s2 <= PIN_IDLE;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Normalise polarity so that 1 always means pressed.
    assign btn_s = s2 ^ PIN_IDLE;

    // Debounce FSM with hold counter; every output is a registered pulse or level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dcnt       <= CNT_ZERO;
            hcnt       <= CNT_ZERO;
            press      <= 1'b0;
            rel_pulse  <= 1'b0;
            level      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            press      <= 1'b0;
            rel_pulse  <= 1'b0;
            long_press <= 1'b0;

            // Hold time keeps running through release bounce so a glitch
            // back to DOWN neither restarts nor re-arms the long-press pulse.
            if (state == DOWN || state == REL_CHK) begin
                if (hcnt != CNT_MAX) begin
                    hcnt <= hcnt + CNT_ONE;
                end
                if (hcnt == LONG_LAST) begin
                    long_press <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    level <= 1'b0;
                    dcnt  <= CNT_ZERO;
                    if (btn_s) begin
                        state <= PRESS_CHK;
                    end
                end

                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        dcnt  <= CNT_ZERO;
                    end else if (dcnt == DEB_LAST) begin
                        state <= DOWN;
                        level <= 1'b1;
                        press <= 1'b1;
                        hcnt  <= CNT_ZERO;
                        dcnt  <= CNT_ZERO;
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end

                DOWN: begin
                    level <= 1'b1;
                    dcnt  <= CNT_ZERO;
                    if (!btn_s) begin
                        state <= REL_CHK;
                    end
                end

                REL_CHK: begin
                    if (btn_s) begin
                        state <= DOWN;
                        dcnt  <= CNT_ZERO;
                    end else if (dcnt == DEB_LAST) begin
                        state     <= IDLE;
                        level     <= 1'b0;
                        rel_pulse <= 1'b1;
                        dcnt      <= CNT_ZERO;
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    dcnt  <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner
module tb_btn_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic press_a, rel_a, level_a, long_a;
    logic press_b, rel_b, level_b, long_b;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   chain_cnt = 0;
    int   a_rise = -100;
    int   a_fall = -100;
    int   b_rise = -100;
    int   b_fall = -100;
    ev_t  qa[$];
    ev_t  qb[$];
    logic bpat [0:5];
    logic cpat [0:12];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (16),
        .ACTIVE_LOW     (1'b0)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_a),
        .press     (press_a),
        .rel_pulse (rel_a),
        .level     (level_a),
        .long_press(long_a)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (16),
        .ACTIVE_LOW     (1'b1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_b),
        .press     (press_b),
        .rel_pulse (rel_b),
        .level     (level_b),
        .long_press(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_ev(input int d, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic chk_ev(input int d, input int kind);
        ev_t e;
        bit  got;
        got = 1'b0;
        e.kind = -1;
        e.cyc  = -1;
        if (d == 0 && qa.size() > 0) begin
            e = qa.pop_front();
            got = 1'b1;
        end else if (d == 1 && qb.size() > 0) begin
            e = qb.pop_front();
            got = 1'b1;
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL sb_unexpected dut=%0d cyc=%0d observed=kind%0d expected=none", d, cyc, kind);
        end
        if (got) begin
            total++;
            assert (e.kind == kind && e.cyc == cyc) else begin
                bad++;
                $error("FAIL sb_event dut=%0d observed=kind%0d@%0d expected=kind%0d@%0d",
                       d, kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // One clock: sample on the falling edge and check everything seen there.
    task automatic tick();
        @(negedge clk);
        if (press_a) begin
            chk_ev(0, K_PRESS);
            chain_cnt++;
        end
        if (rel_a)   chk_ev(0, K_REL);
        if (long_a)  chk_ev(0, K_LONG);
        if (press_b) chk_ev(1, K_PRESS);
        if (rel_b)   chk_ev(1, K_REL);
        if (long_b)  chk_ev(1, K_LONG);
        chk("a_press_rel_excl", {31'd0, press_a & rel_a}, 32'd0);
        if (cyc == a_rise - 1) chk("a_level_before_press", {31'd0, level_a}, 32'd0);
        if (cyc == a_rise)     chk("a_level_at_press", {31'd0, level_a}, 32'd1);
        if (cyc == a_fall - 1) chk("a_level_before_rel", {31'd0, level_a}, 32'd1);
        if (cyc == a_fall)     chk("a_level_at_rel", {31'd0, level_a}, 32'd0);
        if (cyc == b_rise - 1) chk("b_level_before_press", {31'd0, level_b}, 32'd0);
        if (cyc == b_rise)     chk("b_level_at_press", {31'd0, level_b}, 32'd1);
        if (cyc == b_fall - 1) chk("b_level_before_rel", {31'd0, level_b}, 32'd1);
        if (cyc == b_fall)     chk("b_level_at_rel", {31'd0, level_b}, 32'd0);
    endtask

    // Clean press of n samples on dut_a, expectations from the latency rule.
    task automatic hold_a(input int n, input bit want_long);
        int e;
        e = cyc + 1;
        push_ev(0, K_PRESS, e + D + 2);
        if (want_long) push_ev(0, K_LONG, e + D + 2 + L);
        push_ev(0, K_REL, e + n + D + 2);
        a_rise = e + D + 2;
        a_fall = e + n + D + 2;
        btn_a = 1'b1;
        repeat (n) tick();
        btn_a = 1'b0;
        repeat (D + 8) tick();
    endtask

    initial begin
        int e;
        bpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b1;
        repeat (3) tick();
        chk("rst_press_a", {31'd0, press_a}, 32'd0);
        chk("rst_rel_a",   {31'd0, rel_a},   32'd0);
        chk("rst_level_a", {31'd0, level_a}, 32'd0);
        chk("rst_long_a",  {31'd0, long_a},  32'd0);
        chk("rst_press_b", {31'd0, press_b}, 32'd0);
        chk("rst_rel_b",   {31'd0, rel_b},   32'd0);
        chk("rst_level_b", {31'd0, level_b}, 32'd0);
        chk("rst_long_b",  {31'd0, long_b},  32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // Clean press held 50 samples.
        hold_a(50, 1'b1);

        // Bounce on press, then a 2-sample glitch while down.
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                e = cyc + 1;
                push_ev(0, K_PRESS, e + D + 2);
                push_ev(0, K_LONG,  e + D + 2 + L);
                push_ev(0, K_REL,   e + 30 + D + 2);
                a_rise = e + D + 2;
                a_fall = e + 30 + D + 2;
            end
            btn_a = bpat[i];
            tick();
        end
        repeat (9) tick();
        btn_a = 1'b0;
        repeat (2) tick();
        btn_a = 1'b1;
        repeat (18) begin
            tick();
            chk("bounce_level_held", {31'd0, level_a}, 32'd1);
        end
        btn_a = 1'b0;
        repeat (D + 8) tick();

        // Long press, then a short press that must not fire long_press.
        hold_a(40, 1'b1);
        hold_a(5, 1'b0);

        // Reset while pressed: no release, then re-qualification from IDLE.
        e = cyc + 1;
        push_ev(0, K_PRESS, e + D + 2);
        a_rise = e + D + 2;
        a_fall = -100;
        btn_a = 1'b1;
        repeat (10) tick();
        chk("pre_rst_level", {31'd0, level_a}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", {31'd0, level_a}, 32'd0);
        chk("mid_rst_press", {31'd0, press_a}, 32'd0);
        chk("mid_rst_rel",   {31'd0, rel_a},   32'd0);
        chk("mid_rst_long",  {31'd0, long_a},  32'd0);
        rst = 1'b0;
        e = cyc + 1;
        push_ev(0, K_PRESS, e + D + 2);
        push_ev(0, K_LONG,  e + D + 2 + L);
        push_ev(0, K_REL,   e + 20 + D + 2);
        a_rise = e + D + 2;
        a_fall = e + 20 + D + 2;
        repeat (20) tick();
        btn_a = 1'b0;
        repeat (D + 8) tick();

        // Active-low pin: idles high, pressed low for 20 samples.
        e = cyc + 1;
        push_ev(1, K_PRESS, e + D + 2);
        push_ev(1, K_LONG,  e + D + 2 + L);
        push_ev(1, K_REL,   e + 20 + D + 2);
        b_rise = e + D + 2;
        b_fall = e + 20 + D + 2;
        btn_b = 1'b0;
        repeat (20) tick();
        btn_b = 1'b1;
        repeat (D + 8) tick();

        // Five bounced presses counted downstream.
        chain_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 13; i++) begin
                if (i == 4) begin
                    e = cyc + 1;
                    push_ev(0, K_PRESS, e + D + 2);
                    push_ev(0, K_REL,   e + 8 + D + 2);
                    a_rise = e + D + 2;
                    a_fall = e + 8 + D + 2;
                end
                btn_a = cpat[i];
                tick();
            end
            repeat (12) tick();
        end
        chk("chain_press_count", chain_cnt, 32'd5);

        chk("sb_a_drained", qa.size(), 32'd0);
        chk("sb_b_drained", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
